queue_arbiter: RTL and testbench

Round-robin arbiter that shares one `queue` receive port among `NREQ` requesters, such as vector-lane result writers feeding a shared writeback queue. Each requester presents val/rdy messages with a `last` flag. A grant is held (locked) from the first accepted beat until the `last` beat is accepted, so multi-beat packets never interleave. The winner's message passes straight through to the queue with zero added latency, tagged with its source index.

---
 rtl/queue_arbiter_pkg.sv | 6 +
 rtl/queue_arbiter_rr_pick.sv | 36 +++
 rtl/queue_arbiter.sv | 88 ++++++++
 tb/tb_queue_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/queue_arbiter_pkg.sv
// Shared types for the queue arbiter and its round-robin picker.
//   arb_state_t : IDLE arbitrates every cycle; LOCKED holds the grant on one
//                 owner until that owner's last beat is accepted.
package queue_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;
endpackage

// File: rtl/queue_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   cand [NREQ] : candidate vector
//   ptr  [IDW]  : highest-priority index (must be < NREQ)
//   sel  [IDW]  : first candidate at or after ptr, wrapping NREQ-1 -> 0
//   any         : at least one candidate present (sel is 0 otherwise)
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] cand,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  sel,
  output logic            any
);
  int             idx;
  logic [IDW-1:0] idx_w;

  // Scan from the far end back toward ptr so the closest candidate is the
  // last one written and therefore wins. Wrap is modulo NREQ, which need
  // not be a power of two.
  always_comb begin
    sel   = '0;
    any   = 1'b0;
    idx   = 0;
    idx_w = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_w = IDW'(idx);
      if (cand[idx_w]) begin
        sel = idx_w;
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/queue_arbiter.sv
// queue_arbiter: round-robin, packet-locking arbiter in front of one queue.
//   clk, reset              : clock, async active-high reset
//   req_msg/val/last/mask   : per-requester message, valid, last flag, eligibility
//   req_rdy                 : per-requester ready (only the granted one can be 1)
//   send_msg/src/last/val   : winning beat, zero latency, tagged with source index
//   send_rdy                : downstream ready
//   busy                    : a multi-beat packet currently holds the grant
module queue_arbiter
  import queue_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0][WIDTH-1:0] req_msg,
  input  logic [NREQ-1:0]            req_val,
  input  logic [NREQ-1:0]            req_last,
  output logic [NREQ-1:0]            req_rdy,
  input  logic [NREQ-1:0]            req_mask,
  output logic [WIDTH-1:0]           send_msg,
  output logic [IDW-1:0]             send_src,
  output logic                       send_last,
  output logic                       send_val,
  input  logic                       send_rdy,
  output logic                       busy
);
  arb_state_t      state;
  logic [IDW-1:0]  owner, rr_ptr, pick_sel, sel;
  logic [NREQ-1:0] cand;
  logic            pick_any, locked, grant_active, xfer;

  function automatic logic [IDW-1:0] ptr_inc(input logic [IDW-1:0] p);
    return (p == IDW'(NREQ - 1)) ? '0 : p + 1'b1;
  endfunction

  assign cand = req_val & req_mask;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .cand (cand),
    .ptr  (rr_ptr),
    .sel  (pick_sel),
    .any  (pick_any)
  );

  assign locked       = (state == ARB_LOCKED);
  // Owner keeps the grant through bubbles, independent of mask and others.
  assign sel          = locked ? owner : pick_sel;
  assign grant_active = locked | pick_any;

  assign send_msg  = req_msg[sel];
  assign send_src  = sel;
  assign send_last = req_last[sel];
  assign send_val  = !reset && (locked ? req_val[owner] : pick_any);
  assign busy      = locked && !reset;
  assign xfer      = send_val && send_rdy;

  always_comb begin
    req_rdy = '0;
    if (!reset && grant_active && send_rdy) req_rdy[sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ARB_IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else if (xfer) begin
      case (state)
        ARB_IDLE: begin
          if (send_last) rr_ptr <= ptr_inc(sel);
          else begin
            state <= ARB_LOCKED;
            owner <= sel;
          end
        end
        ARB_LOCKED: begin
          if (send_last) begin
            state  <= ARB_IDLE;
            rr_ptr <= ptr_inc(owner);
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_queue_arbiter.sv
module tb_queue_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0][7:0] msg4;
  logic [3:0] val4, last4, mask4, rdy4;
  logic [7:0] smsg4;
  logic [1:0] src4;
  logic slast4, sval4, srdy4, busy4;

  logic [2:0][7:0] msg3;
  logic [2:0] val3, last3, mask3, rdy3;
  logic [7:0] smsg3;
  logic [1:0] src3;
  logic slast3, sval3, srdy3, busy3;

  int checks = 0, failures = 0;
  // Reference model: own = -1 when no packet holds the grant.
  int own4 = -1, ptr4 = 0, own3 = -1, ptr3 = 0;

  queue_arbiter #(.NREQ(4), .WIDTH(8)) dut4 (
    .clk(clk), .reset(reset), .req_msg(msg4), .req_val(val4), .req_last(last4),
    .req_rdy(rdy4), .req_mask(mask4), .send_msg(smsg4), .send_src(src4),
    .send_last(slast4), .send_val(sval4), .send_rdy(srdy4), .busy(busy4));

  queue_arbiter #(.NREQ(3), .WIDTH(8)) dut3 (
    .clk(clk), .reset(reset), .req_msg(msg3), .req_val(val3), .req_last(last3),
    .req_rdy(rdy3), .req_mask(mask3), .send_msg(smsg3), .send_src(src3),
    .send_last(slast3), .send_val(sval3), .send_rdy(srdy3), .busy(busy3));

  function automatic int pick(input int n, input logic [3:0] cand, input int ptr);
    for (int k = 0; k < n; k++) begin
      int i;
      i = (ptr + k) % n;
      if (cand[i]) return i;
    end
    return -1;
  endfunction

  function automatic int exp_sel(input int n, input int own, input int ptr,
                                 input logic [3:0] val, input logic [3:0] mask);
    return (own >= 0) ? own : pick(n, val & mask, ptr);
  endfunction

  function automatic logic exp_val(input int own, input int s, input logic [3:0] val);
    if (own >= 0) return val[own];
    return s >= 0;
  endfunction

  task automatic upd(input int n, input logic [3:0] val, input logic [3:0] last,
                     input logic [3:0] mask, input logic rdy,
                     inout int own, inout int ptr);
    int s;
    s = exp_sel(n, own, ptr, val, mask);
    if (exp_val(own, s, val) && rdy) begin
      if (own < 0) begin
        if (last[s]) ptr = (s + 1) % n;
        else own = s;
      end else if (last[own]) begin
        ptr = (own + 1) % n;
        own = -1;
      end
    end
  endtask

  // Advance both models across the next rising edge, then step off it.
  task automatic tick();
    if (reset) begin
      own4 = -1; ptr4 = 0; own3 = -1; ptr3 = 0;
    end else begin
      upd(4, val4, last4, mask4, srdy4, own4, ptr4);
      upd(3, {1'b0, val3}, {1'b0, last3}, {1'b0, mask3}, srdy3, own3, ptr3);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    val4 = 4'hf; last4 = 4'hf; mask4 = 4'hf; srdy4 = 1'b1;
    for (int i = 0; i < 4; i++) msg4[i] = 8'($urandom);
    val3 = '0; last3 = '1; mask3 = '1; srdy3 = 1'b1; msg3 = '0;
    #2;
    checks++; if (sval4 !== 1'b0) begin failures++; $display("FAIL reset_val got=%b exp=0", sval4); end
    checks++; if (rdy4 !== 4'h0) begin failures++; $display("FAIL reset_rdy got=%b exp=0000", rdy4); end
    checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy4); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (sval4 !== 1'b1 || src4 !== 2'd0) begin failures++; $display("FAIL reset_first_grant val=%b src=%0d exp val=1 src=0", sval4, src4); end
    // Mid-cycle assertion must force outputs low immediately.
    reset = 1'b1;
    #1;
    checks++; if (sval4 !== 1'b0 || rdy4 !== 4'h0) begin failures++; $display("FAIL reset_async val=%b rdy=%b exp 0/0000", sval4, rdy4); end
    @(posedge clk); #1;
    reset = 1'b0; srdy4 = 1'b0;
    @(negedge clk);
    checks++; if (sval4 !== 1'b1 || src4 !== 2'd0) begin failures++; $display("FAIL reset_regrant val=%b src=%0d exp val=1 src=0", sval4, src4); end
    tick();
  endtask

  task automatic test_fairness();
    int fair_exp[6] = '{0, 1, 2, 3, 0, 1};
    val4 = 4'hf; last4 = 4'hf; mask4 = 4'hf; srdy4 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (src4 !== 2'(fair_exp[c]) || rdy4 !== 4'(1 << fair_exp[c]) || sval4 !== 1'b1) begin
        failures++;
        $display("FAIL fairness[%0d] src=%0d rdy=%b exp src=%0d", c, src4, rdy4, fair_exp[c]);
      end
      tick();
    end
  endtask

  task automatic test_burst_lock();
    logic [7:0] beats[3] = '{8'h11, 8'h12, 8'h13};
    val4 = 4'b0001; last4 = 4'hf; srdy4 = 1'b1;
    @(negedge clk);
    checks++; if (src4 !== 2'd0) begin failures++; $display("FAIL burst_setup src=%0d exp=0", src4); end
    tick();
    val4 = 4'b0111;
    for (int b = 0; b < 3; b++) begin
      msg4[1] = beats[b];
      last4 = (b == 2) ? 4'b0111 : 4'b0101;
      @(negedge clk);
      checks++;
      if (src4 !== 2'd1 || smsg4 !== beats[b] || slast4 !== (b == 2) || busy4 !== (b != 0)) begin
        failures++;
        $display("FAIL burst_beat[%0d] src=%0d msg=%h last=%b busy=%b exp src=1 msg=%h", b, src4, smsg4, slast4, busy4, beats[b]);
      end
      tick();
    end
    srdy4 = 1'b0;
    @(negedge clk);
    checks++; if (src4 !== 2'd2 || busy4 !== 1'b0) begin failures++; $display("FAIL burst_next src=%0d busy=%b exp src=2 busy=0", src4, busy4); end
    tick();
  endtask

  task automatic test_bubble_stall();
    srdy4 = 1'b1; val4 = 4'b1000; last4 = 4'b0000;
    @(negedge clk);
    checks++; if (src4 !== 2'd3 || sval4 !== 1'b1) begin failures++; $display("FAIL bubble_start src=%0d val=%b exp src=3", src4, sval4); end
    tick();
    val4 = 4'b0111; last4 = 4'b0111;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (sval4 !== 1'b0 || (rdy4 & 4'b0111) !== 4'h0 || busy4 !== 1'b1) begin
        failures++;
        $display("FAIL bubble[%0d] val=%b rdy=%b busy=%b exp val=0 others=0 busy=1", c, sval4, rdy4, busy4);
      end
      tick();
    end
    val4 = 4'hf; srdy4 = 1'b0; last4 = 4'b0111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (sval4 !== 1'b1 || src4 !== 2'd3 || rdy4 !== 4'h0 || busy4 !== 1'b1) begin
        failures++;
        $display("FAIL stall[%0d] val=%b src=%0d rdy=%b busy=%b exp 1/3/0000/1", c, sval4, src4, rdy4, busy4);
      end
      tick();
    end
    srdy4 = 1'b1; last4 = 4'b1000;
    @(negedge clk);
    checks++; if (src4 !== 2'd3 || rdy4 !== 4'b1000) begin failures++; $display("FAIL stall_release src=%0d rdy=%b exp 3/1000", src4, rdy4); end
    tick();
    srdy4 = 1'b0;
    @(negedge clk);
    checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL bubble_end busy=%b exp=0", busy4); end
    tick();
  endtask

  task automatic test_mask_wrap();
    int alt[4] = '{0, 2, 0, 2};
    int seq[7] = '{0, 2, 2, 2, 0, 1, 2};
    logic [2:0] lastv[7] = '{3'b111, 3'b011, 3'b011, 3'b111, 3'b111, 3'b111, 3'b111};
    val4 = '0;
    val3 = 3'b111; last3 = 3'b111; mask3 = 3'b101; srdy3 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (src3 !== 2'(alt[c]) || sval3 !== 1'b1) begin
        failures++;
        $display("FAIL mask_alt[%0d] src=%0d exp=%0d", c, src3, alt[c]);
      end
      tick();
    end
    // Step 1 starts req 2's burst; the mask widens mid-burst at step 2.
    for (int c = 0; c < 7; c++) begin
      last3 = lastv[c];
      if (c == 2) mask3 = 3'b111;
      @(negedge clk);
      checks++;
      if (src3 !== 2'(seq[c]) || busy3 !== (c == 2 || c == 3)) begin
        failures++;
        $display("FAIL mask_burst[%0d] src=%0d busy=%b exp src=%0d", c, src3, busy3, seq[c]);
      end
      tick();
    end
    val3 = '0;
  endtask

  task automatic test_reset_mid();
    srdy4 = 1'b1; val4 = 4'b0100; last4 = 4'b0000; mask4 = 4'hf;
    @(negedge clk);
    checks++; if (src4 !== 2'd2) begin failures++; $display("FAIL rstmid_grant src=%0d exp=2", src4); end
    tick();
    @(negedge clk);
    checks++; if (busy4 !== 1'b1) begin failures++; $display("FAIL rstmid_locked busy=%b exp=1", busy4); end
    reset = 1'b1;
    #1;
    checks++; if (busy4 !== 1'b0 || sval4 !== 1'b0) begin failures++; $display("FAIL rstmid_force busy=%b val=%b exp 0/0", busy4, sval4); end
    tick();
    reset = 1'b0;
    val4 = 4'hf; last4 = 4'hf;
    @(negedge clk);
    checks++; if (src4 !== 2'd0 || busy4 !== 1'b0) begin failures++; $display("FAIL rstmid_after src=%0d busy=%b exp 0/0", src4, busy4); end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      int s;
      logic ev;
      logic [3:0] erdy, cmpm;
      val4  = 4'($urandom);
      last4 = 4'($urandom) | 4'($urandom);
      mask4 = 4'($urandom) | 4'($urandom);
      srdy4 = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) msg4[i] = 8'($urandom);
      @(negedge clk);
      s  = exp_sel(4, own4, ptr4, val4, mask4);
      ev = exp_val(own4, s, val4);
      erdy = (srdy4 && s >= 0) ? 4'(1 << s) : 4'h0;
      // An owner's ready during its own bubble is not constrained.
      cmpm = (own4 >= 0 && !val4[own4]) ? ~4'(1 << own4) : 4'hf;
      checks++;
      if (sval4 !== ev || busy4 !== (own4 >= 0) || (rdy4 & cmpm) !== (erdy & cmpm)) begin
        failures++;
        $display("FAIL rand_ctl[%0d] val=%b busy=%b rdy=%b exp val=%b busy=%b rdy=%b", c, sval4, busy4, rdy4, ev, own4 >= 0, erdy);
      end
      if (ev) begin
        checks++;
        if (src4 !== 2'(s) || smsg4 !== msg4[s] || slast4 !== last4[s]) begin
          failures++;
          $display("FAIL rand_data[%0d] src=%0d msg=%h last=%b exp src=%0d msg=%h last=%b", c, src4, smsg4, slast4, s, msg4[s], last4[s]);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_burst_lock();
    test_bubble_stall();
    test_mask_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
